mm_reg_accum: RTL and testbench

//   Register-based ROW_NUM x COL_NUM matrix-multiply tile with K-dimension accumulation.

---
 rtl/mm_reg_accum_if.sv | 31 +++
 rtl/mm_reg_accum.sv | 121 ++++++++++++
 tb/tb_mm_reg_accum.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_reg_accum_if.sv
// Slice-in / tile-out bundle for mm_reg_accum; master drives operands and out_ready.
interface mm_reg_accum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int LENGTH     = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_BEATS  = 256
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic                                   in_last;
  logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0]   mat;
  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]   fil;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [ACC_WIDTH*ROW_NUM*COL_NUM-1:0]   res;
  logic [$clog2(MAX_BEATS):0]             beat_cnt;
  logic                                   ovf;
  logic                                   err_overrun;

  modport master (
    output in_valid, in_last, mat, fil, out_ready,
    input  in_ready, out_valid, res, beat_cnt, ovf, err_overrun
  );

  modport slave (
    input  in_valid, in_last, mat, fil, out_ready,
    output in_ready, out_valid, res, beat_cnt, ovf, err_overrun
  );
endinterface

// File: rtl/mm_reg_accum.sv
// Register matrix tile accumulating K-slices until in_last; result 1 cycle after the last beat,
// held while out_ready is low, in_ready = !out_valid | out_ready.
module mm_reg_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int LENGTH     = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1,
  parameter int MAX_BEATS  = 256
) (
  input  logic          clk,
  input  logic          reset,
  mm_reg_accum_if.slave bus
);
  localparam int NE = ROW_NUM * COL_NUM;
  localparam int PW = 2 * DATA_WIDTH + $clog2(LENGTH) + 2;
  // Wide enough to hold accumulator plus a full slice product without losing the true sum.
  localparam int W  = ACC_WIDTH + PW + 2;
  localparam int CW = $clog2(MAX_BEATS) + 1;

  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] MAXV = SIGNED ? (ONE <<< (ACC_WIDTH - 1)) - ONE
                                                : (ONE <<< ACC_WIDTH) - ONE;
  localparam logic signed [W-1:0] MINV = SIGNED ? -(ONE <<< (ACC_WIDTH - 1)) : '0;

  typedef enum logic {FIRST, ACCUM} state_t;

  state_t                      state, state_nxt;
  logic                        first;
  logic                        accept;
  logic                        hit;
  logic [CW-1:0]               cnt_inc;
  logic [ACC_WIDTH*NE-1:0]     acc;
  logic [ACC_WIDTH*NE-1:0]     acc_nxt;
  logic [NE-1:0]               ovf_el;

  function automatic logic signed [W-1:0] ext_op(input logic [DATA_WIDTH-1:0] v);
    return SIGNED ? {{(W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v} : {{(W-DATA_WIDTH){1'b0}}, v};
  endfunction

  function automatic logic signed [W-1:0] ext_acc(input logic [ACC_WIDTH-1:0] v);
    return SIGNED ? {{(W-ACC_WIDTH){v[ACC_WIDTH-1]}}, v} : {{(W-ACC_WIDTH){1'b0}}, v};
  endfunction

  function automatic logic signed [W-1:0] dot(
    input int                                 i,
    input int                                 j,
    input logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0] m,
    input logic [DATA_WIDTH*LENGTH*COL_NUM-1:0] f
  );
    logic signed [W-1:0] s;
    s = '0;
    for (int k = 0; k < LENGTH; k++) begin
      s = s + ext_op(m[(i*LENGTH+k)*DATA_WIDTH +: DATA_WIDTH])
            * ext_op(f[(k*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH]);
    end
    return s;
  endfunction

  // Returns {overflowed, stored value}: clamp or wrap when the true sum leaves the range.
  function automatic logic [ACC_WIDTH:0] fold(input logic signed [W-1:0] s);
    if (s > MAXV) return {1'b1, SATURATE ? MAXV[ACC_WIDTH-1:0] : s[ACC_WIDTH-1:0]};
    if (s < MINV) return {1'b1, SATURATE ? MINV[ACC_WIDTH-1:0] : s[ACC_WIDTH-1:0]};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  assign first        = (state == FIRST);
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_inc      = bus.beat_cnt + CW'(1);
  assign hit          = (cnt_inc >= CW'(MAX_BEATS));

  for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
    for (genvar j = 0; j < COL_NUM; j++) begin : g_col
      localparam int E = i * COL_NUM + j;
      logic signed [W-1:0] base;
      assign base = first ? '0 : ext_acc(acc[E*ACC_WIDTH +: ACC_WIDTH]);
      assign {ovf_el[E], acc_nxt[E*ACC_WIDTH +: ACC_WIDTH]} = fold(base + dot(i, j, bus.mat, bus.fil));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = bus.in_last ? FIRST : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      bus.res         <= '0;
      bus.out_valid   <= 1'b0;
      bus.beat_cnt    <= '0;
      bus.ovf         <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      if (accept && bus.in_last) bus.out_valid <= 1'b1;
      else if (bus.out_ready)    bus.out_valid <= 1'b0;

      // Sticky flags describe the tile in res until the next tile's first beat.
      if (accept) begin
        acc     <= acc_nxt;
        bus.ovf <= (|ovf_el) | (bus.ovf & !first);
        if (bus.in_last) begin
          bus.res         <= acc_nxt;
          bus.beat_cnt    <= '0;
          bus.err_overrun <= bus.err_overrun & !first;
        end else begin
          bus.beat_cnt    <= hit ? CW'(MAX_BEATS) : cnt_inc;
          bus.err_overrun <= hit | (bus.err_overrun & !first);
        end
      end
    end
  end
endmodule

// File: tb/tb_mm_reg_accum.sv
// Two 2x2x2 signed tiles (16-bit acc, MAX_BEATS=4), saturating and wrapping, under identical stimulus.
module tb_mm_reg_accum;
  localparam int AW   = 16;
  localparam int NE   = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mm_reg_accum_if #(.DATA_WIDTH(8), .ROW_NUM(2), .COL_NUM(2), .LENGTH(2),
                    .ACC_WIDTH(AW), .MAX_BEATS(MAXB)) ia ();
  mm_reg_accum_if #(.DATA_WIDTH(8), .ROW_NUM(2), .COL_NUM(2), .LENGTH(2),
                    .ACC_WIDTH(AW), .MAX_BEATS(MAXB)) ib ();

  mm_reg_accum #(.DATA_WIDTH(8), .ROW_NUM(2), .COL_NUM(2), .LENGTH(2), .ACC_WIDTH(AW),
                 .SIGNED(1'b1), .SATURATE(1'b1), .MAX_BEATS(MAXB))
    dut_sat (.clk(clk), .reset(reset), .bus(ia));
  mm_reg_accum #(.DATA_WIDTH(8), .ROW_NUM(2), .COL_NUM(2), .LENGTH(2), .ACC_WIDTH(AW),
                 .SIGNED(1'b1), .SATURATE(1'b0), .MAX_BEATS(MAXB))
    dut_wrap (.clk(clk), .reset(reset), .bus(ib));

  int n_vec = 0;
  int n_bad = 0;
  int m [2][2];
  int f [2][2];

  // Reference: plain integer matrices, index 0 = saturating tile, 1 = wrapping tile.
  bit     exp_ov, exp_first, exp_err;
  int     exp_cnt;
  longint macc [2][NE];
  longint mres [2][NE];
  bit     movf [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint fold(input longint s, input bit sat, output bit o);
    o = (s > 32767) || (s < -32768);
    if (!o) return s;
    if (sat) return (s > 0) ? 64'sd32767 : -64'sd32768;
    return longint'(shortint'(s));
  endfunction

  function automatic logic [63:0] exp_res(input int s);
    logic [63:0] r;
    for (int e = 0; e < NE; e++) r[e*AW +: AW] = 16'(mres[s][e]);
    return r;
  endfunction

  task automatic drive(input bit v, input bit last, input bit ordy);
    logic [31:0] mv, fv;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) mv[(i*2+k)*8 +: 8] = 8'(m[i][k]);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) fv[(k*2+j)*8 +: 8] = 8'(f[k][j]);
    ia.in_valid = v; ia.in_last = last; ia.mat = mv; ia.fil = fv; ia.out_ready = ordy;
    ib.in_valid = v; ib.in_last = last; ib.mat = mv; ib.fil = fv; ib.out_ready = ordy;
  endtask

  task automatic model_edge(input bit v, input bit last, input bit ordy);
    bit took;
    took = v && (!exp_ov || ordy);
    if (took) begin
      for (int s = 0; s < 2; s++) begin
        bit ob;
        ob = 1'b0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            longint d;
            bit o;
            d = 0;
            for (int k = 0; k < 2; k++) d += longint'(m[i][k] * f[k][j]);
            macc[s][i*2+j] = fold((exp_first ? 64'sd0 : macc[s][i*2+j]) + d, s == 0, o);
            ob |= o;
          end
        movf[s] = ob | (movf[s] && !exp_first);
      end
      if (exp_first) exp_err = 1'b0;
      if (last) begin
        for (int s = 0; s < 2; s++) mres[s] = macc[s];
        exp_cnt   = 0;
        exp_first = 1'b1;
      end else begin
        exp_cnt = exp_cnt + 1;
        if (exp_cnt >= MAXB) begin
          exp_cnt = MAXB;
          exp_err = 1'b1;
        end
        exp_first = 1'b0;
      end
    end
    if (took && last) exp_ov = 1'b1;
    else if (ordy)    exp_ov = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid_sat", 64'(ia.out_valid),   64'(exp_ov));
    chk("out_valid_wrp", 64'(ib.out_valid),   64'(exp_ov));
    chk("beat_cnt",      64'(ia.beat_cnt),    64'(exp_cnt));
    chk("err_overrun",   64'(ia.err_overrun), 64'(exp_err));
    chk("err_ovr_wrp",   64'(ib.err_overrun), 64'(exp_err));
    chk("ovf_sat",       64'(ia.ovf),         64'(movf[0]));
    chk("ovf_wrp",       64'(ib.ovf),         64'(movf[1]));
    chk("res_sat",       ia.res,              exp_res(0));
    chk("res_wrp",       ib.res,              exp_res(1));
  endtask

  task automatic step(input bit v, input bit last, input bit ordy);
    drive(v, last, ordy);
    #1;
    chk("in_ready_sat", 64'(ia.in_ready), 64'(!exp_ov || ordy));
    chk("in_ready_wrp", 64'(ib.in_ready), 64'(!exp_ov || ordy));
    @(posedge clk);
    model_edge(v, last, ordy);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit v);
    reset = 1'b1;
    drive(v, 1'b0, 1'b1);
    @(posedge clk);
    exp_ov = 1'b0; exp_first = 1'b1; exp_err = 1'b0; exp_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      movf[s] = 1'b0;
      for (int e = 0; e < NE; e++) begin macc[s][e] = 0; mres[s][e] = 0; end
    end
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1;
    m = '{'{0, 0}, '{0, 0}};
    f = '{'{0, 0}, '{0, 0}};
    drive(1'b0, 1'b0, 1'b0);
    do_reset(1'b0);
    do_reset(1'b0);

    // Single-beat tile
    m = '{'{1, 2}, '{3, 4}};
    f = '{'{5, 6}, '{7, 8}};
    step(1'b1, 1'b1, 1'b0);
    chk("res_2x2_const", ia.res, {16'd50, 16'd43, 16'd22, 16'd19});
    chk("cnt_after_last", 64'(ia.beat_cnt), 64'd0);

    // Three beats of the same slice; previous result drains meanwhile
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("ov_mid_tile", 64'(ia.out_valid), 64'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("res_3beat_const", ia.res, {16'd150, 16'd129, 16'd66, 16'd57});

    // Backpressure, then back-to-back tile with no bubble
    m = '{'{2, 0}, '{0, 2}};
    repeat (5) step(1'b1, 1'b1, 1'b0);
    chk("res_held_const", ia.res, {16'd150, 16'd129, 16'd66, 16'd57});
    step(1'b1, 1'b1, 1'b1);
    chk("b2b_valid", 64'(ia.out_valid), 64'd1);
    chk("b2b_res_const", ia.res, {16'd16, 16'd14, 16'd12, 16'd10});
    step(1'b0, 1'b0, 1'b1);

    // Two beats of (-128)*(-128) overflow the 16-bit accumulator
    m = '{'{-128, 0}, '{0, 0}};
    f = '{'{-128, 0}, '{0, 0}};
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("sat_res_const", 64'(ia.res[15:0]), 64'h7fff);
    chk("sat_ovf_const", 64'(ia.ovf), 64'd1);
    chk("wrap_res_const", 64'(ib.res[15:0]), 64'h8000);
    chk("wrap_ovf_const", 64'(ib.ovf), 64'd1);

    // Overrun: five non-last beats against MAX_BEATS=4
    m = '{'{1, 0}, '{0, 1}};
    f = '{'{1, 1}, '{1, 1}};
    for (int b = 1; b <= 5; b++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("ovr_err_const", 64'(ia.err_overrun), 64'(b >= 4));
      chk("ovr_cnt_const", 64'(ia.beat_cnt), 64'((b >= 4) ? 4 : b));
    end
    step(1'b1, 1'b1, 1'b1);
    chk("ovr_err_kept", 64'(ia.err_overrun), 64'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("ovr_err_cleared", 64'(ia.err_overrun), 64'd0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a 3-beat tile
    m = '{'{9, 9}, '{9, 9}};
    f = '{'{9, 9}, '{9, 9}};
    step(1'b1, 1'b0, 1'b1);
    do_reset(1'b1);
    chk("rst_valid_const", 64'(ia.out_valid), 64'd0);
    m = '{'{1, 2}, '{3, 4}};
    f = '{'{5, 6}, '{7, 8}};
    step(1'b1, 1'b1, 1'b1);
    chk("rst_fresh_const", ia.res, {16'd50, 16'd43, 16'd22, 16'd19});
    step(1'b0, 1'b0, 1'b1);

    // Random traffic: mostly small operands, sometimes full range
    repeat (400) begin
      bit wide;
      wide = ($urandom_range(3) == 0);
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++) begin
          m[i][k] = wide ? int'($urandom_range(255)) - 128 : int'($urandom_range(15)) - 8;
          f[k][i] = wide ? int'($urandom_range(255)) - 128 : int'($urandom_range(15)) - 8;
        end
      step($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
